wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file for the pipelined core. Consumes the MEM/WB pipeline register outputs, selects load data or ALU result, and commits it to a 32-entry × 32-bit register file on the clock edge. Serves the decode stage with two combinational read ports and same-cycle write-to-read bypass, so decode never sees stale data for a register being written back. Also keeps a free-running count of committed writes for debug and performance visibility.

## Interface
Parameters:
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W entries)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mem_wb_RegWrite  input  1  writeback enable from MEM/WB
- mem_wb_MemtoReg  input  1  1 = write load data, 0 = write ALU result
- readdata_in  input  DATA_W  load data from MEM/WB
- alu_result_in  input  DATA_W  ALU result from MEM/WB
- wb_rd  input  ADDR_W  destination register from MEM/WB
- rs1  input  ADDR_W  decode read port 1 index
- rs2  input  ADDR_W  decode read port 2 index
- rdata1  output  DATA_W  read port 1 data (combinational)
- rdata2  output  DATA_W  read port 2 data (combinational)
- wb_data  output  DATA_W  selected writeback value (combinational)
- wb_count  output  32  number of committed register writes

## Operation
- Writeback select: wb_data = mem_wb_MemtoReg ? readdata_in : alu_result_in, always driven, independent of RegWrite.
- Commit: the write is effective when mem_wb_RegWrite = 1 and wb_rd ≠ 0. On the rising edge, regs[wb_rd] ← wb_data, and wb_count increments by 1.
- Register 0 is hardwired to zero. Writes to index 0 are dropped and do not increment wb_count. Reads of index 0 always return 0.
- Read port n (n = 1, 2):
  - index = 0 → 0;
  - else if the write is effective and wb_rd = index → wb_data (bypass);
  - else → regs[index].
- Both ports may bypass in the same cycle when rs1 = rs2 = wb_rd.
- wb_count wraps from 0xFFFF_FFFF to 0. There is no saturation.
- Reset (rst_n = 0): regs[1..31] ← 0 and wb_count ← 0, asynchronously and immediately. Writes are blocked while rst_n is low.

## Timing
- Reset values: every register 0 and wb_count = 0. With reset asserted, rdata1, rdata2 and wb_data follow their combinational definitions over zeroed state (rdata = 0 unless bypassing).
- Write latency is one edge: a value presented in cycle N appears in regs from cycle N+1.
- Bypass latency is zero: the same-cycle read returns the new value in cycle N.
- Reset asserted mid-cycle clears state without waiting for clk. The first write after deassertion is accepted on the first rising edge with rst_n = 1.
- A write with X-free inputs and RegWrite = 0 leaves all state and wb_count unchanged.
- No stall or flush inputs. The upstream pipeline squashes a write by driving RegWrite = 0.

## Test plan
- Reset then read: assert rst_n = 0, release, then sweep rs1/rs2 over 0..31 → all reads 0 and wb_count = 0.
- ALU writeback: RegWrite = 1, MemtoReg = 0, alu_result_in = 0x0000_1234, wb_rd = 5, rs1 = 5 in the same cycle → rdata1 = 0x1234 (bypass). Next cycle with RegWrite = 0 → rdata1 = 0x1234 and wb_count = 1.
- Load writeback and x0: MemtoReg = 1, readdata_in = 0xDEAD_BEEF, wb_rd = 0, rs1 = rs2 = 0 → rdata1 = rdata2 = 0, wb_data = 0xDEAD_BEEF, wb_count unchanged.
- Dual bypass and overwrite: regs[7] = 0x11, then write 0x22 to rd 7 with rs1 = rs2 = 7 → both ports return 0x22 that cycle, and regs[7] = 0x22 afterwards.
- Counter wrap: preload wb_count to 0xFFFF_FFFF via 2^32 − 1 writes, or by force in the bench. One more effective write → wb_count = 0.
- Async reset mid-operation: regs[3] = 0xAAAA_5555, pulse rst_n low between clock edges → rdata for index 3 reads 0 before the next edge, and wb_count = 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Purpose: MEM/WB writeback inputs, decode read ports and debug counter of wb_regfile.
// Latency: n/a (signal bundle only).
// Backpressure: none; the master drives MEM/WB fields and read indices, the slave drives data back.
//
// Ports (signals):
//   mem_wb_RegWrite, mem_wb_MemtoReg, readdata_in, alu_result_in, wb_rd : writeback request
//   rs1, rs2                                                          : decode read indices
//   rdata1, rdata2, wb_data, wb_count                                 : register file responses
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              mem_wb_RegWrite;
    logic              mem_wb_MemtoReg;
    logic [DATA_W-1:0] readdata_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [ADDR_W-1:0] wb_rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       wb_count;

    modport master (
        output mem_wb_RegWrite, mem_wb_MemtoReg, readdata_in, alu_result_in, wb_rd, rs1, rs2,
        input  rdata1, rdata2, wb_data, wb_count
    );

    modport slave (
        input  mem_wb_RegWrite, mem_wb_MemtoReg, readdata_in, alu_result_in, wb_rd, rs1, rs2,
        output rdata1, rdata2, wb_data, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Purpose: writeback mux, 2^ADDR_W x DATA_W architectural register file, commit counter.
// Latency: writes commit on the next rising edge; reads and write-to-read bypass are combinational.
// Backpressure: none; a write is accepted every cycle it is presented with RegWrite=1 and rd!=0.
//
// Ports:
//   clk    : core clock, state updates on rising edge
//   rst_n  : asynchronous active-low reset, clears registers and wb_count
//   bus    : wb_regfile_if slave (MEM/WB writeback fields, decode read ports, wb_count)
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_regfile_if.slave    bus
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [31:0]       wb_count_q;
    logic [31:0]       wb_count_d;

    logic [DATA_W-1:0] wb_data;
    logic              wr_en;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    // Writeback select is always driven, even when no write is requested.
    assign wb_data = bus.mem_wb_MemtoReg ? bus.readdata_in : bus.alu_result_in;

    // Index 0 is the hardwired zero register: writes to it are dropped entirely,
    // including the commit count.
    assign wr_en = bus.mem_wb_RegWrite && (bus.wb_rd != '0);

    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (wr_en) begin
            regs_d[bus.wb_rd] = wb_data;
            wb_count_d        = wb_count_q + 32'd1;   // wraps naturally at 2^32
        end
    end

    // Read ports: zero register first, then same-cycle bypass so decode never
    // sees the stale copy of a register being written back this cycle.
    always_comb begin
        rdata1 = regs_q[bus.rs1];
        if (bus.rs1 == '0) begin
            rdata1 = '0;
        end else if (wr_en && (bus.wb_rd == bus.rs1)) begin
            rdata1 = wb_data;
        end
    end

    always_comb begin
        rdata2 = regs_q[bus.rs2];
        if (bus.rs2 == '0) begin
            rdata2 = '0;
        end else if (wr_en && (bus.wb_rd == bus.rs2)) begin
            rdata2 = wb_data;
        end
    end

    // Reset has priority, so writes are blocked for as long as rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wb_count_q <= wb_count_d;
        end
    end

    assign bus.wb_data  = wb_data;
    assign bus.rdata1   = rdata1;
    assign bus.rdata2   = rdata2;
    assign bus.wb_count = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as a plain array plus a commit tally.
    logic [31:0] m_regs [32];
    logic [31:0] m_count;

    // Bench copy of what is currently being driven.
    logic        s_we, s_mtr;
    logic [31:0] s_rdd, s_alu;
    logic [4:0]  s_rd, s_rs1, s_rs2;

    task automatic drive(input logic we, input logic mtr, input logic [31:0] rdd,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2);
        s_we = we; s_mtr = mtr; s_rdd = rdd; s_alu = alu; s_rd = rd; s_rs1 = r1; s_rs2 = r2;
        bus.mem_wb_RegWrite = we;
        bus.mem_wb_MemtoReg = mtr;
        bus.readdata_in     = rdd;
        bus.alu_result_in   = alu;
        bus.wb_rd           = rd;
        bus.rs1             = r1;
        bus.rs2             = r2;
    endtask

    function automatic logic [31:0] m_wb();
        return s_mtr ? s_rdd : s_alu;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (s_we && s_rd != 5'd0 && s_rd == idx) return m_wb();
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
    endtask

    // Advance one clock: commit into the model on the rising edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n && s_we && s_rd != 5'd0) begin
            m_regs[s_rd] = m_wb();
            m_count      = m_count + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b0;
        model_reset();
        #3;
        checks++;
        if (bus.wb_count !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %h expected %h", bus.wb_count, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'($urandom), $urandom, $urandom, 5'($urandom), 5'(i), 5'(31 - i));
            #1;
            checks += 2;
            if (bus.rdata1 !== 32'd0) begin
                errors++; $display("FAIL reset_rdata1[%0d]: got %h expected 0", i, bus.rdata1);
            end
            if (bus.rdata2 !== 32'd0) begin
                errors++; $display("FAIL reset_rdata2[%0d]: got %h expected 0", 31 - i, bus.rdata2);
            end
            cycle();
        end
        checks++;
        if (bus.wb_count !== 32'd0) begin
            errors++; $display("FAIL reset_count_after_sweep: got %h expected 0", bus.wb_count);
        end
    endtask

    task automatic test_alu_wb();
        drive(1'b1, 1'b0, $urandom, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
        #1;
        checks += 2;
        if (bus.rdata1 !== 32'h1234) begin
            errors++; $display("FAIL alu_bypass: got %h expected %h", bus.rdata1, 32'h1234);
        end
        if (bus.wb_data !== 32'h1234) begin
            errors++; $display("FAIL alu_wb_data: got %h expected %h", bus.wb_data, 32'h1234);
        end
        cycle();
        drive(1'b0, 1'b0, $urandom, $urandom, 5'd5, 5'd5, 5'd0);
        #1;
        checks += 2;
        if (bus.rdata1 !== 32'h1234) begin
            errors++; $display("FAIL alu_stored: got %h expected %h", bus.rdata1, 32'h1234);
        end
        if (bus.wb_count !== 32'd1) begin
            errors++; $display("FAIL alu_count: got %h expected %h", bus.wb_count, 32'd1);
        end
    endtask

    task automatic test_load_x0();
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, $urandom, 5'd0, 5'd0, 5'd0);
        #1;
        checks += 3;
        if (bus.rdata1 !== 32'd0) begin
            errors++; $display("FAIL x0_rdata1: got %h expected 0", bus.rdata1);
        end
        if (bus.rdata2 !== 32'd0) begin
            errors++; $display("FAIL x0_rdata2: got %h expected 0", bus.rdata2);
        end
        if (bus.wb_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_wb_data: got %h expected %h", bus.wb_data, 32'hDEAD_BEEF);
        end
        cycle();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #1;
        checks += 2;
        if (bus.wb_count !== 32'd1) begin
            errors++; $display("FAIL x0_count: got %h expected %h", bus.wb_count, 32'd1);
        end
        if (bus.rdata1 !== 32'd0) begin
            errors++; $display("FAIL x0_after: got %h expected 0", bus.rdata1);
        end
    endtask

    task automatic test_dual_bypass();
        drive(1'b1, 1'b0, $urandom, 32'h11, 5'd7, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 1'b0, $urandom, 32'h22, 5'd7, 5'd7, 5'd7);
        #1;
        checks += 2;
        if (bus.rdata1 !== 32'h22) begin
            errors++; $display("FAIL dual_bypass_rdata1: got %h expected %h", bus.rdata1, 32'h22);
        end
        if (bus.rdata2 !== 32'h22) begin
            errors++; $display("FAIL dual_bypass_rdata2: got %h expected %h", bus.rdata2, 32'h22);
        end
        cycle();
        drive(1'b0, 1'b1, $urandom, $urandom, 5'd7, 5'd7, 5'd5);
        #1;
        checks += 3;
        if (bus.rdata1 !== 32'h22) begin
            errors++; $display("FAIL overwrite_r7: got %h expected %h", bus.rdata1, 32'h22);
        end
        if (bus.rdata2 !== 32'h1234) begin
            errors++; $display("FAIL keep_r5: got %h expected %h", bus.rdata2, 32'h1234);
        end
        if (bus.wb_count !== m_count) begin
            errors++; $display("FAIL dual_count: got %h expected %h", bus.wb_count, m_count);
        end
    endtask

    task automatic test_counter_wrap();
        drive(1'b0, 1'b0, $urandom, $urandom, 5'd9, 5'd9, 5'd0);
        force dut.wb_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wb_count_q;
        m_count = 32'hFFFF_FFFF;
        cycle();
        checks++;
        if (bus.wb_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL count_hold: got %h expected %h", bus.wb_count, 32'hFFFF_FFFF);
        end
        drive(1'b1, 1'b0, $urandom, 32'h0BAD_F00D, 5'd9, 5'd9, 5'd0);
        cycle();
        drive(1'b0, 1'b0, $urandom, $urandom, 5'd9, 5'd9, 5'd0);
        #1;
        checks += 2;
        if (bus.wb_count !== 32'd0) begin
            errors++; $display("FAIL count_wrap: got %h expected 0", bus.wb_count);
        end
        if (bus.rdata1 !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL wrap_r9: got %h expected %h", bus.rdata1, 32'h0BAD_F00D);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        drive(1'b1, 1'b0, $urandom, 32'hAAAA_5555, 5'd3, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 1'b0, $urandom, $urandom, 5'd3, 5'd3, 5'd3);
        #1;
        checks++;
        if (bus.rdata1 !== 32'hAAAA_5555) begin
            errors++; $display("FAIL async_pre_r3: got %h expected %h", bus.rdata1, 32'hAAAA_5555);
        end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checks += 3;
        if (bus.rdata1 !== 32'd0) begin
            errors++; $display("FAIL async_rdata1: got %h expected 0", bus.rdata1);
        end
        if (bus.rdata2 !== 32'd0) begin
            errors++; $display("FAIL async_rdata2: got %h expected 0", bus.rdata2);
        end
        if (bus.wb_count !== 32'd0) begin
            errors++; $display("FAIL async_count: got %h expected 0", bus.wb_count);
        end
        // A write presented while still in reset across an edge must be dropped.
        @(negedge clk);
        drive(1'b1, 1'b0, $urandom, 32'h5151_5151, 5'd4, 5'd3, 5'd3);
        cycle();
        // Release mid-cycle; the next rising edge must accept the write.
        v = $urandom;
        drive(1'b1, 1'b1, v, $urandom, 5'd4, 5'd3, 5'd3);
        #2 rst_n = 1'b1;
        cycle();
        drive(1'b0, 1'b0, $urandom, $urandom, 5'd4, 5'd4, 5'd3);
        #1;
        checks += 3;
        if (bus.rdata1 !== v) begin
            errors++; $display("FAIL post_reset_write: got %h expected %h", bus.rdata1, v);
        end
        if (bus.rdata2 !== 32'd0) begin
            errors++; $display("FAIL post_reset_r3: got %h expected 0", bus.rdata2);
        end
        if (bus.wb_count !== 32'd1) begin
            errors++; $display("FAIL post_reset_count: got %h expected %h", bus.wb_count, 32'd1);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd, r1, r2;
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom);
            drive(($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom, rd, r1, r2);
            #1;
            checks += 4;
            if (bus.rdata1 !== m_read(r1)) begin
                errors++; $display("FAIL rand_rdata1[%0d]: got %h expected %h", n, bus.rdata1, m_read(r1));
            end
            if (bus.rdata2 !== m_read(r2)) begin
                errors++; $display("FAIL rand_rdata2[%0d]: got %h expected %h", n, bus.rdata2, m_read(r2));
            end
            if (bus.wb_data !== m_wb()) begin
                errors++; $display("FAIL rand_wb_data[%0d]: got %h expected %h", n, bus.wb_data, m_wb());
            end
            if (bus.wb_count !== m_count) begin
                errors++; $display("FAIL rand_count[%0d]: got %h expected %h", n, bus.wb_count, m_count);
            end
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        model_reset();
        @(negedge clk);
        test_reset();
        test_alu_wb();
        test_load_x0();
        test_dual_bypass();
        test_counter_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
